// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mult_pkg
// Description : Shared types and widths for the sequential shift-and-add
//               multiplier controller (mult_seq_ctrl) and its adder.
//               Contents: mult_state_t (IDLE/RUN/DONE), MULT_W, PROD_W.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

  localparam int MULT_W = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/FA32.sv
`default_nettype none
// ============================================================================
// Module      : FA32
// Description : 32-bit ripple-carry adder built from a chain of full adders.
//               Ports:
//                 a    in  32  addend
//                 b    in  32  addend
//                 cin  in  1   carry in
//                 sum  out 32  a + b + cin, low 32 bits
//                 cout out 1   carry out of bit 31
// Revision    : 1.0 - initial release
// ============================================================================
module FA32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [32:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[32];

endmodule : FA32
`default_nettype wire

// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mult_seq_ctrl
// Description : Sequential shift-and-add 32x32 unsigned multiplier controller.
//               One shared 32-bit ripple-carry adder (FA32) is used for all
//               iterations. Operands arrive on a valid/ready input handshake,
//               the product leaves on a valid/ready output handshake.
//               Ports:
//                 clk        in  1   rising-edge clock
//                 reset      in  1   asynchronous, active-high reset
//                 in_valid   in  1   operands a/b valid
//                 in_ready   out 1   controller can accept operands (IDLE)
//                 a          in  32  multiplicand
//                 b          in  32  multiplier
//                 out_valid  out 1   product valid, held until accepted (DONE)
//                 out_ready  in  1   consumer accepts product
//                 product    out 64  a*b, unsigned
//               Build option:
//                 MULT_EARLY_TERM_EN - when defined, RUN ends as soon as no set
//                 multiplier bits remain; a barrel shifter performs the
//                 remaining right-shift alignment in that single edge.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  mult_state_t         state;
  mult_state_t         state_next;

  logic [MULT_W-1:0]   mcand;
  logic [MULT_W-1:0]   mplier;
  logic [MULT_W-1:0]   acc_hi;
  logic [MULT_W-1:0]   acc_lo;
  logic [CNT_W-1:0]    cnt;

  logic [MULT_W-1:0]   addend;
  logic [MULT_W-1:0]   sum;
  logic                cout;
  logic                last_iter;
  logic                early_done;

  // Partial product: multiplicand when the current multiplier LSB is set.
  assign addend    = mcand & {MULT_W{mplier[0]}};
  assign last_iter = (cnt == CNT_W'(MULT_W - 1));

  FA32 u_fa32 (
    .a    (acc_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

`ifdef MULT_EARLY_TERM_EN
  // After cnt iterations the remaining (MULT_W - cnt) iterations would only
  // add zero and shift right, so they collapse into one right shift.
  logic [CNT_W:0]      align_sh;
  logic [PROD_W-1:0]   acc_aligned;

  assign align_sh    = (CNT_W + 1)'(MULT_W) - {1'b0, cnt};
  assign acc_aligned = {acc_hi, acc_lo} >> align_sh;
  assign early_done  = (mplier == '0);
`else
  assign early_done  = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid)                state_next = RUN;
      RUN:  if (early_done || last_iter) state_next = DONE;
      DONE: if (out_ready)               state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign product = {acc_hi, acc_lo};

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= a;
            mplier <= b;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
`ifdef MULT_EARLY_TERM_EN
          if (early_done) begin
            {acc_hi, acc_lo} <= acc_aligned;
          end else
`endif
          begin
            // Carry out becomes acc_hi[31]; LSB of the sum drops into acc_lo.
            {acc_hi, acc_lo} <= {cout, sum, acc_lo[MULT_W-1:1]};
            mplier           <= mplier >> 1;
            cnt              <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule : mult_seq_ctrl
`default_nettype wire
